// File: rtl/wb_tgen_pkg.sv
// Shared types and constants for the Wishbone traffic generator.
package wb_tgen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_INDEX = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_ADDR  = 2'd3
  } mode_t;

  localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
  localparam logic [2:0]  CTI_CLASSIC = 3'b000;
  localparam logic [2:0]  CTI_INCR    = 3'b010;
  localparam logic [2:0]  CTI_EOB     = 3'b111;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/wb_tgen_pattern.sv
// Data pattern source: restarts on load, advances one word per step.
// Shared between the write stream and the expected-data stream by reloading.
module wb_tgen_pattern
  import wb_tgen_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 26,
  parameter int LEN_W = 12
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  mode_t         i_mode,
  input  logic [31:0]   i_seed,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] o_word
);

  logic [LEN_W-1:0] r_idx;
  logic [31:0]      r_lfsr;
  logic [LEN_W-1:0] w_shift;

  // Word index and LFSR state; a zero seed would lock the LFSR, so it becomes 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= {LEN_W{1'b0}};
      r_lfsr <= 32'd0;
    end else if (i_load) begin
      r_idx  <= {LEN_W{1'b0}};
      r_lfsr <= (i_seed == 32'd0) ? 32'd1 : i_seed;
    end else if (i_step) begin
      r_idx  <= r_idx + LEN_W'(1);
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  // Pattern word selection.
  always_comb begin
    w_shift = r_idx % LEN_W'(DW);
    case (i_mode)
      MODE_INDEX: o_word = DW'(r_idx);
      MODE_LFSR:  o_word = r_lfsr[DW-1:0];
      MODE_WALK:  o_word = DW'(1'b1) << w_shift;
      MODE_ADDR:  o_word = DW'(i_addr);
      default:    o_word = {DW{1'b0}};
    endcase
  end

endmodule

// File: rtl/wb_traffic_gen.sv
// Wishbone memory test master: writes a pattern, reads it back and counts mismatches.
// Define WB_TGEN_BURST_EN to issue incrementing bursts of BURST beats instead of classic cycles.
module wb_traffic_gen
  import wb_tgen_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 26,
  parameter int LEN_W = 12,
  parameter int TMO   = 255,
  parameter int BURST = 4
) (
  input  logic            sys_clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [AW-1:0]   cfg_base,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [1:0]      cfg_mode,
  input  logic [31:0]     cfg_seed,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     err_cnt,
  output logic            tmo_err,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam int            WD_W = $clog2(TMO + 1);
  localparam logic [AW-1:0] STEP = AW'(DW / 8);
`ifdef WB_TGEN_BURST_EN
  localparam int            BW   = (BURST > 1) ? $clog2(BURST) : 1;
  logic [BW-1:0] r_beat, w_beat_nxt;
`endif

  state_t           r_state, w_state_nxt;
  logic             r_cyc, r_stb, r_we, w_cyc_nxt, w_stb_nxt, w_we_nxt;
  logic [AW-1:0]    r_addr, w_addr_nxt, r_base;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt, r_len, w_len_cur;
  logic [WD_W-1:0]  r_wdog, w_wdog_nxt;
  logic [15:0]      r_err, w_err_nxt;
  logic             r_tmo, w_tmo_nxt, r_pass, w_pass_nxt;
  logic             r_done, r_busy;
  logic [2:0]       r_cti, w_cti_nxt;
  logic [DW/8-1:0]  r_sel;
  mode_t            r_mode;
  logic [31:0]      r_seed, w_seed;
  logic             w_last, w_grp_end, w_load, w_step;
  logic [DW-1:0]    w_word;

  assign w_seed    = (r_state == S_IDLE) ? cfg_seed : r_seed;
  assign w_len_cur = (r_state == S_IDLE) ? cfg_len : r_len;
  assign w_last    = (r_cnt == r_len - LEN_W'(1));

  wb_tgen_pattern #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) u_pattern (
    .i_clk   (sys_clk),
    .i_rst_n (resetn),
    .i_mode  (r_mode),
    .i_seed  (w_seed),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_addr  (r_addr),
    .o_word  (w_word)
  );

  // Run configuration captured on an accepted start.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      r_base <= {AW{1'b0}};
      r_len  <= {LEN_W{1'b0}};
      r_mode <= MODE_INDEX;
      r_seed <= 32'd0;
    end else if ((r_state == S_IDLE) && start) begin
      r_base <= cfg_base;
      r_len  <= cfg_len;
      r_mode <= mode_t'(cfg_mode);
      r_seed <= cfg_seed;
    end
  end

  // Next-state and bus-control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_stb_nxt   = r_stb;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_tmo_nxt   = r_tmo;
    w_pass_nxt  = r_pass;
    w_load      = 1'b0;
    w_step      = 1'b0;
`ifdef WB_TGEN_BURST_EN
    w_beat_nxt  = r_beat;
    w_grp_end   = (r_beat == BW'(BURST - 1));
`else
    w_grp_end   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_err_nxt  = 16'd0;
          w_tmo_nxt  = 1'b0;
          w_pass_nxt = 1'b0;
          w_addr_nxt = cfg_base;
          w_cnt_nxt  = {LEN_W{1'b0}};
          w_load     = 1'b1;
`ifdef WB_TGEN_BURST_EN
          w_beat_nxt = {BW{1'b0}};
`endif
          if (cfg_len == {LEN_W{1'b0}}) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_WR;
            w_cyc_nxt   = 1'b1;
            w_stb_nxt   = 1'b1;
            w_we_nxt    = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR, S_RD: begin
        if (!r_stb) begin
          // Idle gap between phases or burst groups is over; present the next beat.
          w_cyc_nxt = 1'b1;
          w_stb_nxt = 1'b1;
        end else if (wb_ack_i) begin
          if ((r_state == S_RD) && (wb_dat_i != w_word) && (r_err != 16'hFFFF)) begin
            w_err_nxt = r_err + 16'd1;
          end else begin
            w_err_nxt = r_err;
          end
          w_step     = 1'b1;
          w_addr_nxt = r_addr + STEP;
          w_cnt_nxt  = r_cnt + LEN_W'(1);
`ifdef WB_TGEN_BURST_EN
          w_beat_nxt = w_grp_end ? {BW{1'b0}} : r_beat + BW'(1);
`endif
          if (w_last) begin
            w_cyc_nxt = 1'b0;
            w_stb_nxt = 1'b0;
            w_we_nxt  = 1'b0;
            w_cnt_nxt = {LEN_W{1'b0}};
`ifdef WB_TGEN_BURST_EN
            w_beat_nxt = {BW{1'b0}};
`endif
            if (r_state == S_WR) begin
              w_state_nxt = S_RD;
              w_addr_nxt  = r_base;
              w_load      = 1'b1;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else if (w_grp_end) begin
            w_cyc_nxt = 1'b0;
            w_stb_nxt = 1'b0;
          end else begin
            w_stb_nxt = r_stb;
          end
        end else if (r_wdog == WD_W'(TMO - 1)) begin
          w_tmo_nxt   = 1'b1;
          w_cyc_nxt   = 1'b0;
          w_stb_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (r_stb && !wb_ack_i && (w_state_nxt == r_state)) begin
      w_wdog_nxt = r_wdog + WD_W'(1);
    end else begin
      w_wdog_nxt = {WD_W{1'b0}};
    end

    if (w_state_nxt == S_DONE) begin
      w_pass_nxt = (w_err_nxt == 16'd0) && !w_tmo_nxt;
    end else begin
      w_pass_nxt = w_pass_nxt;
    end

`ifdef WB_TGEN_BURST_EN
    if (!w_stb_nxt) begin
      w_cti_nxt = CTI_CLASSIC;
    end else if ((w_cnt_nxt == w_len_cur - LEN_W'(1)) || (w_beat_nxt == BW'(BURST - 1))) begin
      w_cti_nxt = CTI_EOB;
    end else begin
      w_cti_nxt = CTI_INCR;
    end
`else
    w_cti_nxt = CTI_CLASSIC;
`endif
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= {AW{1'b0}};
      r_cnt   <= {LEN_W{1'b0}};
      r_wdog  <= {WD_W{1'b0}};
      r_err   <= 16'd0;
      r_tmo   <= 1'b0;
      r_pass  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_cti   <= CTI_CLASSIC;
      r_sel   <= {(DW/8){1'b0}};
`ifdef WB_TGEN_BURST_EN
      r_beat  <= {BW{1'b0}};
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_stb   <= w_stb_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wdog  <= w_wdog_nxt;
      r_err   <= w_err_nxt;
      r_tmo   <= w_tmo_nxt;
      r_pass  <= w_pass_nxt;
      r_done  <= (w_state_nxt == S_DONE);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_cti   <= w_cti_nxt;
      r_sel   <= w_stb_nxt ? {(DW/8){1'b1}} : {(DW/8){1'b0}};
`ifdef WB_TGEN_BURST_EN
      r_beat  <= w_beat_nxt;
`endif
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err;
  assign tmo_err   = r_tmo;
  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_stb;
  assign wb_we_o   = r_we;
  assign wb_addr_o = r_addr;
  assign wb_dat_o  = (r_stb && r_we) ? w_word : {DW{1'b0}};
  assign wb_sel_o  = r_sel;
  assign wb_cti_o  = r_cti;

endmodule

// File: tb/tb_wb_traffic_gen.sv
// Directed bench for wb_traffic_gen with a small acking memory and a bus monitor.
`timescale 1ns/1ps
module tb_wb_traffic_gen;

  logic        sys_clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [25:0] cfg_base = 26'd0;
  logic [11:0] cfg_len = 12'd0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [31:0] cfg_seed = 32'd0;
  logic        busy, done, pass, tmo_err;
  logic [15:0] err_cnt;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [25:0] wb_addr_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;

  logic [31:0] mem [0:255];
  logic        ack_r;
  logic        withhold = 1'b0;
  logic [25:0] corrupt_addr = 26'h3FF_FFFF;

  logic [25:0] la [0:127];
  logic [31:0] ld [0:127];
  logic        lw [0:127];
  logic [2:0]  lc [0:127];
  int nlog = 0, ndone = 0, ncycact = 0, tcyc = 0, t_stb = 0, t_tmo = 0;
  logic prev_stb = 1'b0, prev_tmo = 1'b0;
  int ntot = 0, npass = 0, nfail = 0;

  always #5 sys_clk = ~sys_clk;

  wb_traffic_gen dut (
    .sys_clk(sys_clk), .resetn(resetn), .start(start),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_mode(cfg_mode), .cfg_seed(cfg_seed),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .tmo_err(tmo_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  // Slave acks every other cycle while strobed; one chosen read address returns a flipped bit.
  always @(posedge sys_clk or negedge resetn) begin
    if (!resetn) ack_r <= 1'b0;
    else         ack_r <= wb_cyc_o && wb_stb_o && !ack_r && !withhold;
  end
  assign wb_ack_i = ack_r;
  assign wb_dat_i = mem[wb_addr_o[9:2]] ^
                    ((!wb_we_o && (wb_addr_o == corrupt_addr)) ? 32'h1 : 32'h0);

  // Monitor: memory writes, beat log, done pulses, stb/timeout edge times.
  always @(negedge sys_clk) begin
    tcyc     <= tcyc + 1;
    prev_stb <= wb_stb_o;
    prev_tmo <= tmo_err;
    if (wb_stb_o && !prev_stb) t_stb <= tcyc;
    if (tmo_err && !prev_tmo)  t_tmo <= tcyc;
    if (done)     ndone   <= ndone + 1;
    if (wb_cyc_o) ncycact <= ncycact + 1;
    if (wb_ack_i && wb_stb_o) begin
      la[nlog[6:0]] <= wb_addr_o;
      ld[nlog[6:0]] <= wb_dat_o;
      lw[nlog[6:0]] <= wb_we_o;
      lc[nlog[6:0]] <= wb_cti_o;
      nlog <= nlog + 1;
      if (wb_we_o) mem[wb_addr_o[9:2]] <= wb_dat_o;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [25:0] b, input logic [11:0] l, input logic [1:0] m,
                      input logic [31:0] sd);
    @(negedge sys_clk);
    cfg_base = b; cfg_len = l; cfg_mode = m; cfg_seed = sd; start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    chk(tag, 64'(n < 3000), 64'd1);
  endtask

  initial begin
    int s, d0, c0;
    logic [6:0] k;
    logic [2:0] cti_exp [0:5];
`ifdef WB_TGEN_BURST_EN
    cti_exp[0] = 3'd2; cti_exp[1] = 3'd2; cti_exp[2] = 3'd2;
    cti_exp[3] = 3'd7; cti_exp[4] = 3'd2; cti_exp[5] = 3'd7;
`else
    for (int i = 0; i < 6; i++) cti_exp[i] = 3'd0;
`endif

    repeat (3) @(negedge sys_clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_err",  64'(err_cnt), 64'd0);
    chk("rst_tmo",  64'(tmo_err), 64'd0);
    chk("rst_cyc",  64'(wb_cyc_o), 64'd0);
    chk("rst_cti",  64'(wb_cti_o), 64'd0);
    chk("rst_sel",  64'(wb_sel_o), 64'd0);
    resetn = 1'b1;

    // Index pattern, with a stray start mid-run that must be ignored.
    s = nlog; d0 = ndone;
    kick(26'h100, 12'd8, 2'd0, 32'd0);
    repeat (3) @(negedge sys_clk);
    cfg_len = 12'd0; start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    wait_done("r1_done");
    chk("r1_pass", 64'(pass), 64'd1);
    chk("r1_err",  64'(err_cnt), 64'd0);
    @(negedge sys_clk);
    chk("r1_nbeats", 64'(nlog - s), 64'd16);
    chk("r1_ndone",  64'(ndone - d0), 64'd1);
    for (int i = 0; i < 16; i++) begin
      k = 7'(s + i);
      chk("r1_addr", 64'(la[k]), 64'(26'h100 + 26'(4 * (i % 8))));
      chk("r1_we",   64'(lw[k]), 64'(i < 8));
      if (i < 8) chk("r1_wdata", 64'(ld[k]), 64'(i));
    end

    // LFSR with zero seed.
    s = nlog;
    kick(26'h200, 12'd8, 2'd1, 32'd0);
    wait_done("r2_done");
    chk("r2_pass", 64'(pass), 64'd1);
    @(negedge sys_clk);
    chk("r2_w0", 64'(ld[7'(s)]),     64'h0000_0001);
    chk("r2_w1", 64'(ld[7'(s + 1)]), 64'h8020_0003);
    chk("r2_w2", 64'(ld[7'(s + 2)]), 64'hC030_0002);
    chk("r2_w3", 64'(ld[7'(s + 3)]), 64'h6018_0001);

    // Walking one with read word 3 corrupted.
    s = nlog;
    corrupt_addr = 26'h30C;
    kick(26'h300, 12'd8, 2'd2, 32'd0);
    wait_done("r3_done");
    chk("r3_err",  64'(err_cnt), 64'd1);
    chk("r3_pass", 64'(pass), 64'd0);
    @(negedge sys_clk);
    corrupt_addr = 26'h3FF_FFFF;
    chk("r3_w3", 64'(ld[7'(s + 3)]), 64'h8);
    chk("r3_w7", 64'(ld[7'(s + 7)]), 64'h80);
    chk("r3_err_hold", 64'(err_cnt), 64'd1);

    // Zero length: done next cycle, no bus activity.
    s = nlog; c0 = ncycact;
    kick(26'h100, 12'd0, 2'd0, 32'd0);
    chk("l0_done", 64'(done), 64'd1);
    chk("l0_pass", 64'(pass), 64'd1);
    chk("l0_busy", 64'(busy), 64'd1);
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("l0_done_off", 64'(done), 64'd0);
    chk("l0_busy_off", 64'(busy), 64'd0);
    chk("l0_nbeats", 64'(nlog - s), 64'd0);
    chk("l0_nocyc",  64'(ncycact - c0), 64'd0);

    // Address pattern across the top of the address space.
    s = nlog;
    kick(26'h3FF_FFFC, 12'd2, 2'd3, 32'd0);
    wait_done("wrap_done");
    chk("wrap_pass", 64'(pass), 64'd1);
    @(negedge sys_clk);
    chk("wrap_a0", 64'(la[7'(s)]),     64'h3FF_FFFC);
    chk("wrap_d0", 64'(ld[7'(s)]),     64'h03FF_FFFC);
    chk("wrap_a1", 64'(la[7'(s + 1)]), 64'h0);
    chk("wrap_d1", 64'(ld[7'(s + 1)]), 64'h0);

    // Cycle type per beat for a 6-word run.
    s = nlog;
    kick(26'h040, 12'd6, 2'd0, 32'd0);
    wait_done("cti_done");
    chk("cti_pass", 64'(pass), 64'd1);
    @(negedge sys_clk);
    chk("cti_nbeats", 64'(nlog - s), 64'd12);
    for (int i = 0; i < 12; i++) chk("cti_beat", 64'(lc[7'(s + i)]), 64'(cti_exp[i % 6]));

    // Ack withheld: watchdog fires 255 cycles after stb rises.
    withhold = 1'b1;
    kick(26'h000, 12'd4, 2'd0, 32'd0);
    wait_done("tmo_done");
    chk("tmo_flag", 64'(tmo_err), 64'd1);
    chk("tmo_pass", 64'(pass), 64'd0);
    chk("tmo_cyc",  64'(wb_cyc_o), 64'd0);
    @(negedge sys_clk);
    chk("tmo_delay", 64'(t_tmo - t_stb), 64'd255);
    withhold = 1'b0;

    // Reset in the middle of the write phase.
    kick(26'h080, 12'd8, 2'd0, 32'd0);
    repeat (4) @(negedge sys_clk);
    chk("mid_cyc_before", 64'(wb_cyc_o), 64'd1);
    chk("mid_sel_before", 64'(wb_sel_o), 64'hF);
    d0 = ndone;
    #2 resetn = 1'b0;
    #1;
    chk("mid_cyc_rst",  64'(wb_cyc_o), 64'd0);
    chk("mid_stb_rst",  64'(wb_stb_o), 64'd0);
    chk("mid_busy_rst", 64'(busy), 64'd0);
    repeat (2) @(negedge sys_clk);
    resetn = 1'b1;
    repeat (20) @(negedge sys_clk);
    chk("mid_no_done", 64'(ndone - d0), 64'd0);
    chk("mid_pass",    64'(pass), 64'd0);
    chk("mid_tmo",     64'(tmo_err), 64'd0);
    chk("mid_cyc_idle", 64'(wb_cyc_o), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/wb_traffic_gen.md
WB_TRAFFIC_GEN -- requirements
Module: wb_traffic_gen

Interface
REQ-001 SHALL have parameter DW, default 32, Wishbone data width; legal values 8, 16, 32.
REQ-002 SHALL have parameter AW, default 26, Wishbone byte-address width.
REQ-003 SHALL have parameter LEN_W, default 12, width of the transfer-length field.
REQ-004 SHALL have parameter TMO, default 255, ack-timeout limit in cycles.
REQ-005 SHALL have parameter BURST, default 4, beats per burst group when bursting is compiled in.
REQ-006 Ports, with clock and reset first:
- sys_clk  in  1  sole clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request.
- cfg_base  in  AW  start byte address.
- cfg_len  in  LEN_W  number of words.
- cfg_mode  in  2  pattern select.
- cfg_seed  in  32  LFSR seed.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- pass  out  1  result of the last run.
- err_cnt  out  16  mismatch count.
- tmo_err  out  1  timeout flag.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls.
- wb_addr_o  out  AW  address.
- wb_dat_o  out  DW  write data.
- wb_sel_o  out  DW/8  byte selects.
- wb_cti_o  out  3  cycle type.
- wb_ack_i  in  1  acknowledge.
- wb_dat_i  in  DW  read data.

Function
REQ-007 FSM states SHALL be IDLE, WR, RD, DONE; `start` SHALL be sampled only in IDLE and ignored otherwise.
REQ-008 On `start`, the block SHALL latch the cfg_* inputs, clear err_cnt and tmo_err, and go to WR, or go directly to DONE if cfg_len==0.
REQ-009 In WR, the block SHALL hold cyc=stb=we=1, sel all ones, and current address/data until ack; each ack SHALL advance the address by DW/8 bytes, modulo 2^AW (wrap).
REQ-010 After cfg_len write acks, the block SHALL deassert cyc/stb for exactly one cycle, reload the address to cfg_base and the pattern generator to its start value, and enter RD.
REQ-011 In RD, the block SHALL behave as in WR with we=0; on each ack it SHALL compare wb_dat_i with the regenerated expected word, and on mismatch increment err_cnt, saturating at 16'hFFFF.
REQ-012 After cfg_len read acks, the block SHALL go to DONE; DONE SHALL last one cycle with done=1, set pass = (err_cnt==0 && !tmo_err), and return to IDLE.
REQ-013 Patterns SHALL be:
- mode 0: word index, truncated or zero-extended to DW.
- mode 1: 32-bit Galois LFSR, polynomial 0x80200003, seeded with cfg_seed, replaced by 1 when the seed is 0, stepped per word, low DW bits used.
- mode 2: walking one, 1<<(index mod DW).
- mode 3: byte address, truncated to DW.
REQ-014 A watchdog SHALL count cycles with stb=1 and no ack; on reaching TMO it SHALL set tmo_err, drop cyc/stb, and go to DONE (pass=0).
REQ-015 The watchdog SHALL clear on every ack and on every phase change.
REQ-016 busy SHALL be 1 in WR, RD and DONE.
REQ-017 pass and err_cnt SHALL hold their values until the next accepted start.
REQ-018 An ack arriving while stb=0 SHALL be ignored.

Reset
REQ-019 resetn low SHALL, asynchronously, put the FSM in IDLE and clear all outputs to 0, including pass, err_cnt and tmo_err, with wb_cti_o=3'b000.
REQ-020 A reset during a run SHALL abandon the run, issue no done pulse, and deassert cyc within the reset.

Configuration
REQ-021 When WB_TGEN_BURST_EN is defined, the block SHALL issue incrementing bursts: wb_cti_o=3'b010 on each beat except the last beat of every BURST-beat group, and on the final word of the phase, which SHALL carry 3'b111.
REQ-022 When WB_TGEN_BURST_EN is defined, the block SHALL hold cyc through a burst group and deassert it for one cycle between groups.
REQ-023 When WB_TGEN_BURST_EN is undefined, wb_cti_o SHALL be constant 3'b000 (classic cycles).

Structure
REQ-024 Package wb_tgen_pkg SHALL hold the state enum, the pattern-mode enum, the LFSR polynomial constant and the CTI constants (CLASSIC, INCR, EOB).
REQ-025 Sub-module wb_tgen_pattern (mode, seed, load, step -> DW word) SHALL be instantiated twice, once for the write stream and once for the expected-data stream, or once and reloaded between phases.

Verification
REQ-026 Scenario: DW=32, base 0x100, len 8, mode 0, ideal memory with 1-cycle ack -> writes 0..7 to 0x100..0x11C, then 8 reads, done pulse, pass=1, err_cnt=0.
REQ-027 Scenario: mode 1, seed 0 -> first word 0x00000001, and the read phase reproduces the same 8-word sequence, pass=1.
REQ-028 Scenario: the memory model corrupts read word 3 -> err_cnt=1, pass=0.
REQ-029 Scenario: ack withheld -> tmo_err=1 exactly 255 cycles after stb rises, done pulse, pass=0.
REQ-030 Scenario: base 0x3FFFFFC, len 2 -> second address 0x0000000 (wrap).
REQ-031 Scenario: resetn dropped mid-WR -> cyc=0 immediately and no done pulse.
REQ-032 Scenario: start at len 0 -> done on the next cycle with pass=1 and no Wishbone activity.
REQ-033 Scenario: with WB_TGEN_BURST_EN defined, len 6 and BURST 4 -> cti sequence 2,2,2,7,2,7.
